// File: rtl/aqed_fifo_sc_monitor.sv
// rtl/aqed_fifo_sc_monitor.sv - A-QED FIFO self-consistency monitor with NUM_CHK orig/dup check channels
// Optional feature: define AQED_RESP_BOUND_EN to enable per-channel response-bound checking (rb_fail).
module aqed_fifo_sc_monitor #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 17,
  parameter int NUM_CHK    = 2,
  parameter int BOUND_MULT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_CHK-1:0] orig_sel,
  input  logic [NUM_CHK-1:0] dup_sel,
  input  logic               dut_full,
  output logic [DATA_W-1:0]  dut_wdata,
  output logic               dut_wen,
  input  logic [DATA_W-1:0]  dut_rdata,
  input  logic               dut_rvalid,
  output logic               dut_ren,
  input  logic               out_ready,
  input  logic [15:0]        depth,
  output logic [NUM_CHK-1:0] qed_done,
  output logic [NUM_CHK-1:0] qed_check,
  output logic               rb_fail
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DUP = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_DONE     = 2'd3
  } chk_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t        state     [NUM_CHK];
  chk_state_t        state_nxt [NUM_CHK];

  logic [DATA_W-1:0] cap_data  [NUM_CHK];
  logic [DATA_W-1:0] out_orig  [NUM_CHK];
  logic [CNT_W-1:0]  orig_idx  [NUM_CHK];
  logic [CNT_W-1:0]  dup_idx   [NUM_CHK];
  logic [NUM_CHK-1:0] orig_seen;

  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;

  logic               wr;
  logic               rd;
  logic               norm_wr;
  logic               inj;
  logic [NUM_CHK-1:0] inj_hot;
  logic [NUM_CHK-1:0] tag_hot;
  logic [NUM_CHK-1:0] orig_hit;
  logic [NUM_CHK-1:0] dup_hit;
  logic [NUM_CHK-1:0] active;
  logic [DATA_W-1:0]  inj_data;

  // Pick the lowest waiting channel whose duplicate is requested; only possible while the DUT has room.
  always_comb begin
    inj      = 1'b0;
    inj_hot  = '0;
    inj_data = '0;
    for (int c = 0; c < NUM_CHK; c++) begin
      if (!inj && state[c] == ST_WAIT_DUP && dup_sel[c] && !dut_full) begin
        inj        = 1'b1;
        inj_hot[c] = 1'b1;
        inj_data   = cap_data[c];
      end
    end
  end

  // Write-port mux: a duplicate injection steals the write slot from the input stream.
  always_comb begin
    in_ready  = ~dut_full & ~inj;
    dut_wen   = inj | (in_valid & ~dut_full);
    dut_wdata = inj ? inj_data : in_data;
    wr        = dut_wen & ~dut_full;
    norm_wr   = wr & ~inj;
    dut_ren   = out_ready;
    rd        = dut_ren & dut_rvalid;
  end

  // Tag at most one original per accepted bench item: lowest idle channel that asked for it.
  always_comb begin
    tag_hot = '0;
    if (norm_wr && wr_cnt != CNT_MAX) begin
      for (int c = 0; c < NUM_CHK; c++) begin
        if (tag_hot == '0 && state[c] == ST_IDLE && orig_sel[c]) begin
          tag_hot[c] = 1'b1;
        end
      end
    end
  end

  // Output-side matching of read positions against the recorded orig/dup write positions.
  always_comb begin
    orig_hit = '0;
    dup_hit  = '0;
    active   = '0;
    for (int c = 0; c < NUM_CHK; c++) begin
      active[c]   = (state[c] == ST_WAIT_DUP) || (state[c] == ST_WAIT_OUT);
      orig_hit[c] = rd && active[c] && (rd_cnt == orig_idx[c]);
      dup_hit[c]  = rd && (state[c] == ST_WAIT_OUT) && (rd_cnt == dup_idx[c]);
    end
  end

  // Channel next-state: IDLE -> WAIT_DUP -> WAIT_OUT -> DONE, DONE held until reset.
  always_comb begin
    for (int c = 0; c < NUM_CHK; c++) begin
      state_nxt[c] = state[c];
      case (state[c])
        ST_IDLE:     if (tag_hot[c]) state_nxt[c] = ST_WAIT_DUP;
        ST_WAIT_DUP: if (inj_hot[c]) state_nxt[c] = ST_WAIT_OUT;
        ST_WAIT_OUT: if (dup_hit[c]) state_nxt[c] = ST_DONE;
        ST_DONE:     state_nxt[c] = ST_DONE;
        default:     state_nxt[c] = ST_IDLE;
      endcase
    end
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHK; c++) begin
      if (reset) state[c] <= ST_IDLE;
      else       state[c] <= state_nxt[c];
    end
  end

  // Saturating write/read position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
      if (rd && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Per-channel capture of the original, duplicate position, observed original and final verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      orig_seen <= '0;
      qed_done  <= '0;
      qed_check <= '0;
      for (int c = 0; c < NUM_CHK; c++) begin
        cap_data[c] <= '0;
        out_orig[c] <= '0;
        orig_idx[c] <= '0;
        dup_idx[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHK; c++) begin
        if (tag_hot[c]) begin
          cap_data[c] <= in_data;
          orig_idx[c] <= wr_cnt;
        end
        if (inj_hot[c]) begin
          dup_idx[c] <= wr_cnt;
        end
        if (orig_hit[c]) begin
          out_orig[c]  <= dut_rdata;
          orig_seen[c] <= 1'b1;
        end
        if (dup_hit[c]) begin
          qed_done[c]  <= 1'b1;
          qed_check[c] <= (dut_rdata == out_orig[c]);
        end
      end
    end
  end

`ifdef AQED_RESP_BOUND_EN
  localparam int PROD_W = CNT_W + 3;

  logic [PROD_W-1:0] bound;
  logic [CNT_W-1:0]  rb_cnt [NUM_CHK];
  logic              rb_hit;

  assign bound = PROD_W'(BOUND_MULT) * PROD_W'(depth);

  // Flag any active channel whose original has not come out within the bound.
  always_comb begin
    rb_hit = 1'b0;
    for (int c = 0; c < NUM_CHK; c++) begin
      if (active[c] && !orig_seen[c] && (PROD_W'(rb_cnt[c]) >= bound)) rb_hit = 1'b1;
    end
  end

  // Count reads since the original was tagged, stopping once it has been seen at the output.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHK; c++) begin
      if (reset || state[c] == ST_IDLE) begin
        rb_cnt[c] <= '0;
      end else if (active[c] && rd && !orig_seen[c] && rb_cnt[c] != CNT_MAX) begin
        rb_cnt[c] <= rb_cnt[c] + 1'b1;
      end
    end
  end

  // Sticky response-bound violation flag.
  always_ff @(posedge clk) begin
    if (reset)       rb_fail <= 1'b0;
    else if (rb_hit) rb_fail <= 1'b1;
  end
`else
  logic unused_depth;

  assign unused_depth = ^depth;
  assign rb_fail      = 1'b0;
`endif

endmodule

// File: tb/tb_aqed_fifo_sc_monitor.sv
// tb/tb_aqed_fifo_sc_monitor.sv - directed scoreboard bench for aqed_fifo_sc_monitor with a behavioural FIFO
module tb_aqed_fifo_sc_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  orig_sel;
  logic [1:0]  dup_sel;
  logic        dut_full;
  logic [15:0] dut_wdata;
  logic        dut_wen;
  logic [15:0] dut_rdata;
  logic        dut_rvalid;
  logic        dut_ren;
  logic        out_ready;
  logic [15:0] depth;
  logic [1:0]  qed_done;
  logic [1:0]  qed_check;
  logic        rb_fail;

`ifdef AQED_RESP_BOUND_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    int   ch;
    logic check;
  } sb_t;
  sb_t sb [$];

  // behavioural memory-core FIFO
  logic [15:0] mem [64];
  int          wp = 0;
  int          rp = 0;
  int          cap = 16;
  logic        force_full = 1'b0;
  logic        corrupt = 1'b0;
  int          six_cnt = 0;

  assign dut_full   = force_full || ((wp - rp) >= cap);
  assign dut_rvalid = (wp != rp);
  assign dut_rdata  = mem[rp[5:0]];

  always #5 clk = ~clk;

  aqed_fifo_sc_monitor #(
    .DATA_W(16), .CNT_W(17), .NUM_CHK(2), .BOUND_MULT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .orig_sel(orig_sel), .dup_sel(dup_sel),
    .dut_full(dut_full), .dut_wdata(dut_wdata), .dut_wen(dut_wen),
    .dut_rdata(dut_rdata), .dut_rvalid(dut_rvalid), .dut_ren(dut_ren),
    .out_ready(out_ready), .depth(depth),
    .qed_done(qed_done), .qed_check(qed_check), .rb_fail(rb_fail)
  );

  always @(posedge clk) begin
    if (reset) begin
      wp      <= 0;
      rp      <= 0;
      six_cnt <= 0;
    end else begin
      if (dut_wen && !dut_full) begin
        if (corrupt && dut_wdata == 16'd6 && six_cnt == 1) mem[wp[5:0]] <= 16'd9;
        else mem[wp[5:0]] <= dut_wdata;
        if (dut_wdata == 16'd6) six_cnt <= six_cnt + 1;
        wp <= wp + 1;
      end
      if (dut_ren && dut_rvalid) rp <= rp + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_item(input logic [15:0] d, input logic [1:0] osel);
    in_data  = d;
    in_valid = 1'b1;
    orig_sel = osel;
    tick();
    in_valid = 1'b0;
    orig_sel = 2'b00;
  endtask

  task automatic inject(input logic [1:0] dsel);
    dup_sel = dsel;
    tick();
    dup_sel = 2'b00;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && wp != rp; i++) tick();
    out_ready = 1'b0;
    chk("drain_empty", 32'(wp - rp), 32'd0);
  endtask

  task automatic read_n(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_done();
    sb_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < 100 && !qed_done[e.ch]; i++) tick();
      chk($sformatf("qed_done_ch%0d", e.ch), 32'(qed_done[e.ch]), 32'd1);
      chk($sformatf("qed_check_ch%0d", e.ch), 32'(qed_check[e.ch]), 32'(e.check));
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    orig_sel  = 2'b00;
    dup_sel   = 2'b00;
    out_ready = 1'b0;
    depth     = 16'd4;

    // reset state
    tick();
    tick();
    chk("rst_qed_done", 32'(qed_done), 32'd0);
    chk("rst_qed_check", 32'(qed_check), 32'd0);
    chk("rst_rb_fail", 32'(rb_fail), 32'd0);
    chk("rst_dut_wen", 32'(dut_wen), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dut_ren0", 32'(dut_ren), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("rst_dut_ren1", 32'(dut_ren), 32'd1);
    out_ready = 1'b0;
    reset = 1'b0;
    tick();

    // matching orig/dup pair on channel 0
    push_item(16'd5, 2'b00);
    push_item(16'd6, 2'b01);
    push_item(16'd7, 2'b00);
    dup_sel = 2'b01;
    #1;
    chk("t1_inj_in_ready", 32'(in_ready), 32'd0);
    chk("t1_inj_wen", 32'(dut_wen), 32'd1);
    chk("t1_inj_wdata", 32'(dut_wdata), 32'd6);
    inject(2'b01);
    sb.push_back('{ch: 0, check: 1'b1});
    drain();
    wait_done();

    // corrupted duplicate
    corrupt = 1'b1;
    do_reset();
    chk("t2_rst_done", 32'(qed_done), 32'd0);
    push_item(16'd5, 2'b00);
    push_item(16'd6, 2'b01);
    push_item(16'd7, 2'b00);
    inject(2'b01);
    sb.push_back('{ch: 0, check: 1'b0});
    drain();
    wait_done();
    corrupt = 1'b0;

    // tag/inject priority across channels
    do_reset();
    push_item(16'h11, 2'b11);
    push_item(16'h22, 2'b10);
    dup_sel  = 2'b11;
    in_valid = 1'b1;
    in_data  = 16'h55;
    #1;
    chk("t3_ch0_wdata", 32'(dut_wdata), 32'h11);
    chk("t3_ch0_in_ready", 32'(in_ready), 32'd0);
    chk("t3_ch0_wen", 32'(dut_wen), 32'd1);
    tick();
    chk("t3_ch1_wdata", 32'(dut_wdata), 32'h22);
    chk("t3_ch1_in_ready", 32'(in_ready), 32'd0);
    tick();
    dup_sel  = 2'b00;
    in_valid = 1'b0;
    #1;
    chk("t3_after_in_ready", 32'(in_ready), 32'd1);
    sb.push_back('{ch: 0, check: 1'b1});
    sb.push_back('{ch: 1, check: 1'b1});
    drain();
    wait_done();
    wait_done();
    chk("t3_done_both", 32'(qed_done), 32'd3);

    // duplicate request held off by a full DUT
    do_reset();
    push_item(16'h21, 2'b01);
    force_full = 1'b1;
    dup_sel    = 2'b01;
    #1;
    chk("t4_full_wen", 32'(dut_wen), 32'd0);
    chk("t4_full_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("t4_full_wen_hold", 32'(dut_wen), 32'd0);
    force_full = 1'b0;
    #1;
    chk("t4_free_wen", 32'(dut_wen), 32'd1);
    chk("t4_free_wdata", 32'(dut_wdata), 32'h21);
    tick();
    dup_sel = 2'b00;
    sb.push_back('{ch: 0, check: 1'b1});
    drain();
    wait_done();

    // original withheld beyond the response bound (2*4 = 8 reads)
    depth = 16'd2;
    do_reset();
    for (int i = 0; i < 8; i++) push_item(16'h100 + 16'(i), 2'b00);
    push_item(16'h77, 2'b01);
    read_n(8);
    tick();
    tick();
    chk("rb_withheld", 32'(rb_fail), 32'(RB_EN));

    // reset while channel 0 waits for its duplicate output
    inject(2'b01);
    reset = 1'b1;
    tick();
    chk("rst_mid_done", 32'(qed_done), 32'd0);
    chk("rst_mid_rb_fail", 32'(rb_fail), 32'd0);
    reset = 1'b0;
    tick();
    push_item(16'd3, 2'b01);
    push_item(16'd4, 2'b00);
    inject(2'b01);
    sb.push_back('{ch: 0, check: 1'b1});
    drain();
    wait_done();
    chk("fresh_rb_fail", 32'(rb_fail), 32'd0);

    // original delivered on the 7th read stays within the bound
    do_reset();
    for (int i = 0; i < 6; i++) push_item(16'h200 + 16'(i), 2'b00);
    push_item(16'h88, 2'b01);
    read_n(7);
    tick();
    tick();
    tick();
    chk("rb_in_bound", 32'(rb_fail), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
